amp_enable_sequencer: RTL and testbench
=======================================

# amp_enable_sequencer

Per-axis amplifier enable sequencer sitting downstream of the current/command safety checker. It consumes the checker's per-cycle trip flag, qualifies it with a consecutive-cycle filter, and latches a fault that drops the amplifier enable and parks the DAC command at midscale. The host must explicitly clear the fault before re-enabling. It sits between the host register file (enable and clear requests, raw DAC command) and the DAC/amplifier pins.

## Interface
- TRIP_COUNT, 16: consecutive `safety_trip` cycles in ENABLED needed to latch a fault; legal range 1..255.
- SETTLE_CYCLES, 1000: cycles held in SETTLING after enable, with trips ignored; legal range 1..65535.
- DAC_MID, 16'h8000: DAC code driven whenever the amplifier is not ENABLED.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- enable_req  in  1  host enable level; 1 requests amplifier on.
- clear_fault  in  1  host fault-clear pulse; honoured only in FAULT with enable_req=0.
- safety_trip  in  1  per-cycle trip flag from the safety checker; active high.
- dac_cmd_in  in  16  host current command, offset binary.
- dac_cmd_out  out  16  command to the DAC.
- amp_enable  out  1  amplifier enable pin.
- fault_latched  out  1  1 while in FAULT.
- seq_state  out  2  current state, for status readback.

## Operation
- States and encodings: DISABLED=0, SETTLING=1, ENABLED=2, FAULT=3.
- DISABLED
  - Outputs: amp_enable=0, dac_cmd_out=DAC_MID.
  - enable_req=1: go to SETTLING and load the settle counter with SETTLE_CYCLES-1.
- SETTLING
  - Outputs: amp_enable=1, dac_cmd_out=DAC_MID; safety_trip ignored; trip counter held at 0.
  - enable_req=0: go to DISABLED.
  - Otherwise the settle counter decrements each cycle; on the cycle it reads 0, go to ENABLED.
- ENABLED
  - Outputs: amp_enable=1, dac_cmd_out=dac_cmd_in registered (one-cycle pass-through).
  - Trip counter, 8 bits: increments on safety_trip=1 and clears on safety_trip=0; it saturates and never wraps.
  - When safety_trip=1 and the counter equals TRIP_COUNT-1: go to FAULT.
  - enable_req=0: go to DISABLED.
  - Fault wins if both conditions occur in the same cycle.
- FAULT
  - Outputs: amp_enable=0, dac_cmd_out=DAC_MID, fault_latched=1.
  - clear_fault=1 with enable_req=0: go to DISABLED and clear the trip counter.
  - clear_fault with enable_req=1 is ignored; the host must drop enable first.
  - safety_trip has no effect in FAULT.
- seq_state always equals the registered state encoding.

## Timing
- All outputs are registered. State changes and output changes occur on the clk edge after the qualifying input sample.
- Reset (reset=0 sampled at a clk edge), from any state including mid-settle or FAULT:
  - next cycle: state=DISABLED, amp_enable=0, dac_cmd_out=DAC_MID, fault_latched=0, seq_state=0;
  - settle counter and trip counter cleared;
  - reset takes priority over every other input.
- Enable latency: enable_req rises at edge N. SETTLING is visible after edge N+1. ENABLED is visible after edge N+1+SETTLE_CYCLES.
- First pass-through sample: dac_cmd_in appears on dac_cmd_out one cycle after ENABLED is entered.
- Fault latency: with TRIP_COUNT consecutive trips beginning at edge T, FAULT and amp_enable=0 are visible after edge T+TRIP_COUNT. A single non-trip cycle restarts the count.
- TRIP_COUNT=1: a single trip cycle latches the fault.
- Clear latency: a qualifying clear_fault at edge C gives DISABLED after edge C+1. Re-enable needs a fresh enable_req=1, which passes through full settling again.
- enable_req held high through reset: SETTLING is entered on the first cycle after reset deasserts.

## Test plan
- Reset mid-SETTLING (cycle 500 of 1000) -> next cycle seq_state=0, amp_enable=0, dac_cmd_out=16'h8000; no transition to ENABLED ever follows.
- enable_req=1 with SETTLE_CYCLES=1000, dac_cmd_in=16'hA000, safety_trip pulsing during settle -> no fault; seq_state=2 exactly 1001 cycles after the request; dac_cmd_out=16'hA000 one cycle later.
- In ENABLED with TRIP_COUNT=16: 15 trips, 1 clear cycle, 15 trips -> stays ENABLED; then 16 consecutive trips -> fault_latched=1, amp_enable=0, dac_cmd_out=16'h8000 after the 16th edge.
- Fault condition and enable_req=0 in the same cycle -> seq_state=3, not 0.
- In FAULT: clear_fault with enable_req=1 -> remains FAULT. Drop enable_req, then clear_fault -> seq_state=0 next cycle. Re-raise enable_req -> full settle repeated.
- TRIP_COUNT=1: a single safety_trip cycle in ENABLED -> FAULT on the next edge.

Source files
------------

// File: rtl/amp_enable_sequencer.sv
// amp_enable_sequencer
//   Per-axis amplifier enable sequencer. Qualifies the safety checker's
//   per-cycle trip flag with a consecutive-cycle filter and latches a fault
//   that drops the amplifier enable and parks the DAC at midscale. A latched
//   fault is released only by a host clear issued while enable is low.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low
//   enable_req     host enable level (1 = amplifier on)
//   clear_fault    host fault-clear pulse, honoured in FAULT with enable_req=0
//   safety_trip    per-cycle trip flag from the safety checker
//   dac_cmd_in     host current command, offset binary
//   dac_cmd_out    registered command to the DAC
//   amp_enable     registered amplifier enable pin
//   fault_latched  registered, 1 while in FAULT
//   seq_state      registered state encoding for status readback
module amp_enable_sequencer #(
  parameter int unsigned TRIP_COUNT    = 16,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [15:0] DAC_MID       = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_req,
  input  logic        clear_fault,
  input  logic        safety_trip,
  input  logic [15:0] dac_cmd_in,
  output logic [15:0] dac_cmd_out,
  output logic        amp_enable,
  output logic        fault_latched,
  output logic [1:0]  seq_state
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SETTLING = 2'd1,
    ENABLED  = 2'd2,
    FAULT    = 2'd3
  } state_e;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  TRIP_LAST   = 8'(TRIP_COUNT - 1);

  state_e      state_q, state_d;
  logic [15:0] settle_q, settle_d;
  logic [7:0]  trip_q, trip_d;
  logic [15:0] dac_q, dac_d;
  logic        amp_q, amp_d;
  logic        flt_q, flt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= DISABLED;
      settle_q <= '0;
      trip_q   <= '0;
      dac_q    <= DAC_MID;
      amp_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      trip_q   <= trip_d;
      dac_q    <= dac_d;
      amp_q    <= amp_d;
      flt_q    <= flt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    trip_d   = '0;

    case (state_q)
      DISABLED: begin
        if (enable_req) begin
          state_d  = SETTLING;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLING: begin
        // Trips are ignored here; trip counter stays at its default of 0.
        if (!enable_req)          state_d  = DISABLED;
        else if (settle_q == '0)  state_d  = ENABLED;
        else                      settle_d = settle_q - 16'd1;
      end
      ENABLED: begin
        if (safety_trip)
          trip_d = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
        // Fault outranks an enable drop in the same cycle.
        if (safety_trip && (trip_q == TRIP_LAST)) state_d = FAULT;
        else if (!enable_req)                     state_d = DISABLED;
      end
      FAULT: begin
        if (clear_fault && !enable_req) state_d = DISABLED;
      end
      default: state_d = DISABLED;
    endcase

    // Counter only carries history while we remain in ENABLED.
    if (state_d != ENABLED) trip_d = '0;

    // Outputs are registered from the next state so they change on the same
    // edge as seq_state. The command passes through only on cycles that both
    // start and stay in ENABLED, giving one cycle of midscale on entry.
    amp_d = (state_d == SETTLING) || (state_d == ENABLED);
    flt_d = (state_d == FAULT);
    dac_d = ((state_q == ENABLED) && (state_d == ENABLED)) ? dac_cmd_in : DAC_MID;
  end

  assign dac_cmd_out   = dac_q;
  assign amp_enable    = amp_q;
  assign fault_latched = flt_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_amp_enable_sequencer.sv
module tb_amp_enable_sequencer;

  localparam logic [15:0] MID = 16'h8000;

  logic        clk = 1'b0;
  logic        rst0, rst1, en, clr, trip;
  logic [15:0] din;
  logic [15:0] dac0, dac1;
  logic        amp0, amp1, flt0, flt1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  // Main instance: TRIP_COUNT=16, SETTLE_CYCLES=1000.
  amp_enable_sequencer #(.TRIP_COUNT(16), .SETTLE_CYCLES(1000), .DAC_MID(MID)) u_dut0 (
    .clk(clk), .reset(rst0), .enable_req(en), .clear_fault(clr),
    .safety_trip(trip), .dac_cmd_in(din), .dac_cmd_out(dac0),
    .amp_enable(amp0), .fault_latched(flt0), .seq_state(st0));

  // Boundary instance: TRIP_COUNT=1, short settle.
  amp_enable_sequencer #(.TRIP_COUNT(1), .SETTLE_CYCLES(4), .DAC_MID(MID)) u_dut1 (
    .clk(clk), .reset(rst1), .enable_req(en), .clear_fault(clr),
    .safety_trip(trip), .dac_cmd_in(din), .dac_cmd_out(dac1),
    .amp_enable(amp1), .fault_latched(flt1), .seq_state(st1));

  typedef struct packed {
    logic        d;
    logic [1:0]  st;
    logic [15:0] dac;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  // Inputs are already set; record what must be visible after the next edge.
  task automatic tick(input logic d, input logic [1:0] st, input logic [15:0] dac,
                      input string nm);
    q.push_back(exp_t'{d, st, dac});
    nq.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  exp_t        e;
  string       enm;
  logic [1:0]  a_st;
  logic [15:0] a_dac;
  logic        a_amp, a_flt, x_amp, x_flt;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e     = q.pop_front();
        enm   = nq.pop_front();
        a_st  = e.d ? st1  : st0;
        a_dac = e.d ? dac1 : dac0;
        a_amp = e.d ? amp1 : amp0;
        a_flt = e.d ? flt1 : flt0;
        x_amp = (e.st == 2'd1) || (e.st == 2'd2);
        x_flt = (e.st == 2'd3);
        checks++;
        if (a_st !== e.st || a_dac !== e.dac || a_amp !== x_amp || a_flt !== x_flt) begin
          errors++;
          $display("FAIL %s @%0t: got st=%0d amp=%0b flt=%0b dac=%h, want st=%0d amp=%0b flt=%0b dac=%h",
                   enm, $time, a_st, a_amp, a_flt, a_dac, e.st, x_amp, x_flt, e.dac);
        end
      end
    end
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; en = 1'b0; clr = 1'b0; trip = 1'b0; din = 16'hA000;
    @(negedge clk);

    // Reset state, reset priority over enable, enable held through reset.
    tick(0, 2'd0, MID, "rst");
    tick(0, 2'd0, MID, "rst");
    en = 1'b1;
    tick(0, 2'd0, MID, "rst_priority");
    rst0 = 1'b1;
    tick(0, 2'd1, MID, "en_through_rst");
    for (int i = 0; i < 499; i++) tick(0, 2'd1, MID, "settle_a");
    rst0 = 1'b0;
    tick(0, 2'd0, MID, "rst_mid_settle");
    rst0 = 1'b1; en = 1'b0;
    for (int i = 0; i < 1010; i++) tick(0, 2'd0, MID, "stay_disabled");

    // Full settle with trips pulsing; ENABLED 1001 edges after the request.
    en = 1'b1; din = 16'hA000;
    for (int k = 1; k <= 1000; k++) begin
      trip = (k % 3 == 0);
      tick(0, 2'd1, MID, "settle_b");
    end
    trip = 1'b1;  // sampled while still SETTLING: must be ignored
    tick(0, 2'd2, MID, "enter_enabled");
    trip = 1'b0;
    tick(0, 2'd2, 16'hA000, "first_pass");

    // 15 trips, gap, 15 trips, gap: no fault.
    for (int i = 0; i < 15; i++) begin
      trip = 1'b1; din = 16'h1000 + 16'(i);
      tick(0, 2'd2, din, "trip15_a");
    end
    trip = 1'b0; din = 16'h2000;
    tick(0, 2'd2, 16'h2000, "trip_gap_a");
    for (int i = 0; i < 15; i++) begin
      trip = 1'b1; din = 16'h2100 + 16'(i);
      tick(0, 2'd2, din, "trip15_b");
    end
    trip = 1'b0; din = 16'h2200;
    tick(0, 2'd2, 16'h2200, "trip_gap_b");

    // 16 consecutive trips: fault on the 16th edge.
    for (int i = 0; i < 15; i++) begin
      trip = 1'b1; din = 16'h3000 + 16'(i);
      tick(0, 2'd2, din, "trip16_run");
    end
    din = 16'h3FFF;
    tick(0, 2'd3, MID, "fault16");

    // FAULT behaviour and clearing.
    trip = 1'b0; clr = 1'b1; en = 1'b1;
    tick(0, 2'd3, MID, "clear_with_en_ignored");
    clr = 1'b0; trip = 1'b1;
    tick(0, 2'd3, MID, "trip_in_fault");
    trip = 1'b0; en = 1'b0;
    tick(0, 2'd3, MID, "fault_hold");
    clr = 1'b1;
    tick(0, 2'd0, MID, "clear");
    clr = 1'b0;
    tick(0, 2'd0, MID, "disabled_after_clear");

    // Re-enable repeats the full settle.
    en = 1'b1; din = 16'h5555;
    for (int i = 0; i < 1000; i++) tick(0, 2'd1, MID, "resettle");
    tick(0, 2'd2, MID, "reenter_enabled");
    tick(0, 2'd2, 16'h5555, "reenable_pass");

    // Fault and enable drop in the same cycle: fault wins.
    for (int i = 0; i < 15; i++) begin
      trip = 1'b1;
      tick(0, 2'd2, 16'h5555, "trip15_c");
    end
    en = 1'b0;
    tick(0, 2'd3, MID, "fault_beats_disable");
    trip = 1'b0; rst0 = 1'b0;
    tick(0, 2'd0, MID, "rst_from_fault");
    rst0 = 1'b1;
    tick(0, 2'd0, MID, "disabled_after_rst");

    // TRIP_COUNT=1 instance.
    rst0 = 1'b0; rst1 = 1'b1; en = 1'b1; din = 16'h1234;
    for (int i = 0; i < 4; i++) tick(1, 2'd1, MID, "tc1_settle");
    tick(1, 2'd2, MID, "tc1_enter");
    tick(1, 2'd2, 16'h1234, "tc1_pass");
    trip = 1'b1;
    tick(1, 2'd3, MID, "tc1_single_trip_fault");
    trip = 1'b0; en = 1'b0; clr = 1'b1;
    tick(1, 2'd0, MID, "tc1_clear");
    clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) tick(1, 2'd1, MID, "tc1_resettle");
    tick(1, 2'd2, MID, "tc1_reenter");
    din = 16'hBEEF;
    tick(1, 2'd2, 16'hBEEF, "tc1_pass2");
    en = 1'b0;
    tick(1, 2'd0, MID, "tc1_drop_enable");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
